seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a common-anode, multi-digit seven-segment display. It shares one hex-digit decoder across `NUM_DIGITS` digits, steps through them with a fixed on-time and a ghost-suppression blanking gap, and drives active-low segment and anode pins. A valid/ready port accepts new display values, and they are committed only at frame boundaries so the display never tears. It sits between the UART status/debug logic and the board's display pins.

---
 rtl/display_pkg.sv | 20 ++
 rtl/seg7_scan_ctrl_if.sv | 12 +
 rtl/decoder_bin2hex.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bits needed to count up to the larger of the two slot durations.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display value offer channel: hex nibbles plus decimal points, valid/ready.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    value_valid;
  logic                    value_ready;

  modport master (output value_in, output dp_in, output value_valid, input value_ready);
  modport slave  (input value_in, input dp_in, input value_valid, output value_ready);
endinterface

// File: rtl/decoder_bin2hex.sv
// Hex nibble to active-low seven-segment pattern; bit 6 = a ... bit 0 = g.
module decoder_bin2hex
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Common-anode lookup: a 0 bit lights the segment.
  always_comb begin
    seg_n = SEG_OFF;
    unique case (nibble)
      4'h0: seg_n = ~7'h7E;
      4'h1: seg_n = ~7'h30;
      4'h2: seg_n = ~7'h6D;
      4'h3: seg_n = ~7'h79;
      4'h4: seg_n = ~7'h33;
      4'h5: seg_n = ~7'h5B;
      4'h6: seg_n = ~7'h5F;
      4'h7: seg_n = ~7'h70;
      4'h8: seg_n = ~7'h7F;
      4'h9: seg_n = ~7'h7B;
      4'hA: seg_n = ~7'h77;
      4'hB: seg_n = ~7'h1F;
      4'hC: seg_n = ~7'h4E;
      4'hD: seg_n = ~7'h3D;
      4'hE: seg_n = ~7'h4F;
      4'hF: seg_n = ~7'h47;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OFF    | display dark, counter held at 0, pending values commit here
// BLANK  | all anodes off for BLANK_CYC cycles ahead of a digit
// SHOW   | anode of digit idx driven for ON_CYC cycles
module seg7_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYC     = 100000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  lz_blank_en,
  seg7_scan_ctrl_if.slave       bus,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_tick
);

  localparam int CW = cnt_width(ON_CYC, BLANK_CYC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic                    pending, ready_q;
  logic                    xfer, commit;

  logic [NUM_DIGITS-1:0]   lz_zero;
  logic                    digit_blank;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg_n;

  assign bus.value_ready = ready_q;
  assign xfer   = bus.value_valid & ready_q;
  // Commit only at a frame boundary so a value never tears mid-scan.
  assign commit = pending & (wrap | (state_q == ST_OFF));

  // State, slot counter and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state, counter terminal compares and frame wrap detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == ON_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Shadow capture on transfer, shadow-to-active commit, and the ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      if (xfer) begin
        shadow_val <= bus.value_in;
        shadow_dp  <= bus.dp_in;
      end
      if (commit) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
      if (xfer)        pending <= 1'b1;
      else if (commit) pending <= 1'b0;
      // Ready returns one cycle after the commit has cleared pending.
      if (xfer)          ready_q <= 1'b0;
      else if (!pending) ready_q <= 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_zero = '0;
    lz_zero[NUM_DIGITS-1] = (active_val[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz_zero[i] = lz_zero[i+1] & (active_val[4*i +: 4] == 4'h0);
    end
  end

  assign digit_blank = lz_blank_en & (idx_q != '0) & lz_zero[idx_q];
  assign nibble      = active_val[4*int'(idx_q) +: 4];

  decoder_bin2hex u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg_n)
  );

  // Registered pins; blanked digits keep their anode and decimal point.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (state_q == ST_SHOW) begin
        seg_n <= digit_blank ? SEG_OFF : dec_seg_n;
        dp_n  <= ~active_dp[idx_q];
        an_n  <= ~(NUM_DIGITS'(1) << idx_q);
      end else begin
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
        an_n  <= '1;
      end
    end
  end

endmodule
